multicycle_ctrl: RTL and testbench
==================================

Name: multicycle_ctrl

Overview:
- Multi-cycle control sequencer for the 32-bit RISC datapath. It replaces the single-cycle combinational decoder: instruction memory and data memory share one port, and the ALU is reused for PC+4, address generation and execution.
- Sits between the instruction register (opcode field) and the datapath muxes and strobes of the CPU top.
- Emits one Moore-style control vector per state.
- Raises Instr_Done for one cycle when each instruction retires.

Parameters:
- OPW, 6, opcode field width.
- STW, 4, state register width (state encodings 0..12).

Ports:
- Clk  in  1  system clock, rising edge.
- Rst  in  1  reset, asynchronous, active-high.
- Opcode  in  6  IR[31:26], valid from DECODE onward.
- ZeroFlag  in  1  ALU zero result.
- Mem_Ready  in  1  memory access complete (used only with MEM_WAIT_EN).
- PC_Write  out  1  load PC.
- IorD  out  1  memory address select: 0 = PC, 1 = ALUOut.
- IR_Write  out  1  load instruction register.
- Sig_Mem_Read  out  1  memory read strobe.
- Sig_Mem_Write  out  1  memory write strobe.
- Sig_Mem_to_Reg  out  1  write-back source: 1 = MDR.
- RegDest  out  1  destination register: 1 = rd, 0 = rt.
- Sig_Reg_Write  out  1  register file write.
- ALUSrcA  out  1  0 = PC, 1 = rs.
- ALUSrcB  out  2  0 = rt, 1 = const 4, 2 = sign-extended immediate, 3 = sign-extended immediate << 2.
- ALUOp  out  3  0 = ADD, 1 = SUB, 2 = decode funct.
- PCSource  out  2  0 = ALU result, 1 = ALUOut register, 2 = jump target.
- Instr_Done  out  1  retire pulse.
- Illegal  out  1  sticky, set on an unknown opcode.
- State  out  4  current state, for debug.

Behaviour:
- Opcodes: RTYPE=0x00, J=0x02, BEQ=0x04, ADDI=0x08, LW=0x23, SW=0x2B. Any other value is illegal.
- States and transitions:
  - FETCH(0) -> DECODE(1).
  - DECODE dispatches on Opcode: LW/SW -> MEM_ADDR(2); RTYPE -> EXEC_R(6); BEQ -> BRANCH(8); J -> JUMP(9); ADDI -> ADDI_EX(10); other -> TRAP(12).
  - MEM_ADDR -> MEM_RD(3) if LW, MEM_WR(5) if SW.
  - MEM_RD -> MEM_WB(4) -> FETCH.
  - MEM_WR -> FETCH.
  - EXEC_R -> R_WB(7) -> FETCH.
  - BRANCH -> FETCH.
  - JUMP -> FETCH.
  - ADDI_EX -> ADDI_WB(11) -> FETCH.
  - TRAP: absorbing; leaves only on Rst.
- Control vector per state (unlisted outputs are 0):
  - FETCH: Sig_Mem_Read=1, IorD=0, IR_Write=1, ALUSrcA=0, ALUSrcB=1, ALUOp=ADD, PCSource=0, PC_Write=1.
  - DECODE: ALUSrcA=0, ALUSrcB=3, ALUOp=ADD (precomputes branch target into ALUOut).
  - MEM_ADDR: ALUSrcA=1, ALUSrcB=2, ALUOp=ADD.
  - MEM_RD: Sig_Mem_Read=1, IorD=1.
  - MEM_WB: Sig_Reg_Write=1, Sig_Mem_to_Reg=1, RegDest=0.
  - MEM_WR: Sig_Mem_Write=1, IorD=1.
  - EXEC_R: ALUSrcA=1, ALUSrcB=0, ALUOp=2.
  - R_WB: Sig_Reg_Write=1, RegDest=1, Sig_Mem_to_Reg=0.
  - BRANCH: ALUSrcA=1, ALUSrcB=0, ALUOp=SUB, PCSource=1, PC_Write=ZeroFlag (this is the only Mealy output).
  - JUMP: PCSource=2, PC_Write=1.
  - ADDI_EX: ALUSrcA=1, ALUSrcB=2, ALUOp=ADD.
  - ADDI_WB: Sig_Reg_Write=1, RegDest=0.
- Latency in cycles: LW=5, SW=4, RTYPE=4, ADDI=4, BEQ=3, J=3.
- Instr_Done is a registered pulse, high in the first FETCH cycle after a retiring state (MEM_WB, MEM_WR, R_WB, BRANCH, JUMP, ADDI_WB). It is not asserted for the first FETCH after reset.
- Illegal: set on the DECODE->TRAP transition and held until Rst. In TRAP every strobe is 0.
- Reset:
  - Asserting Rst at any time, including mid-instruction, forces State=FETCH, Illegal=0 and Instr_Done=0 immediately, without waiting for a clock edge.
  - While Rst is high, all strobes (PC_Write, IR_Write, Sig_Mem_Read, Sig_Mem_Write, Sig_Reg_Write) are gated to 0.
  - The first active FETCH is the first rising edge after Rst deasserts.
- Opcode is sampled only in DECODE and MEM_ADDR. Changes at any other time are ignored.

Optional Feature:
- MEM_WAIT_EN, when defined:
  - FETCH, MEM_RD and MEM_WR hold their state until Mem_Ready=1.
  - In FETCH, IR_Write and PC_Write are asserted only in the cycle where Mem_Ready=1; Sig_Mem_Read stays high throughout the wait.
  - In MEM_WR, Sig_Mem_Write stays high until Mem_Ready=1.
- When not defined: Mem_Ready is ignored, every memory state lasts exactly one cycle, and the latencies are as listed above.

Decomposition:
- Package cpu_ctrl_pkg holds:
  - the opcode localparams;
  - the state encoding localparams;
  - the ALUOp, ALUSrcB and PCSource encodings.
  The ALU-control block shares this package.
- One sub-module, ctrl_decode_rom: purely combinational, state (plus ZeroFlag) -> control vector.
- The FSM registers and next-state logic stay in multicycle_ctrl.

Test Plan:
- Reset then Opcode=0x00 held -> States 0,1,6,7,0; Sig_Reg_Write=1 and RegDest=1 only in state 7; Instr_Done pulses at cycle 5.
- Opcode=0x23 -> States 0,1,2,3,4,0; Sig_Mem_Read=1 with IorD=1 in state 3; Sig_Mem_to_Reg=1 in state 4.
- Opcode=0x04 with ZeroFlag=1 -> PC_Write=1 and PCSource=1 in state 8. Repeat with ZeroFlag=0 -> PC_Write=0; next state is 0 in both cases.
- Opcode=0x3F -> State=12 after DECODE, Illegal=1, all strobes 0 for 20 cycles. Then pulse Rst -> State=0, Illegal=0.
- Rst asserted mid-cycle during MEM_WR (state 5) -> State=0 and Sig_Mem_Write=0 before the next Clk edge.
- With MEM_WAIT_EN defined, Mem_Ready=0 for 3 cycles during FETCH -> state stays 0 and IR_Write=0; IR_Write=PC_Write=1 only in the Mem_Ready=1 cycle.

Source files
------------

// File: rtl/cpu_ctrl_pkg.sv
// rtl/cpu_ctrl_pkg.sv - shared opcodes, state encodings and control-field encodings for the multi-cycle CPU control
package cpu_ctrl_pkg;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEM_ADDR = 4'd2,
        S_MEM_RD   = 4'd3,
        S_MEM_WB   = 4'd4,
        S_MEM_WR   = 4'd5,
        S_EXEC_R   = 4'd6,
        S_R_WB     = 4'd7,
        S_BRANCH   = 4'd8,
        S_JUMP     = 4'd9,
        S_ADDI_EX  = 4'd10,
        S_ADDI_WB  = 4'd11,
        S_TRAP     = 4'd12
    } state_t;

    localparam logic [2:0] ALUOP_ADD   = 3'd0;
    localparam logic [2:0] ALUOP_SUB   = 3'd1;
    localparam logic [2:0] ALUOP_FUNCT = 3'd2;

    localparam logic [1:0] SRCB_RT      = 2'd0;
    localparam logic [1:0] SRCB_FOUR    = 2'd1;
    localparam logic [1:0] SRCB_IMM     = 2'd2;
    localparam logic [1:0] SRCB_IMM_SH2 = 2'd3;

    localparam logic [1:0] PCSRC_ALU    = 2'd0;
    localparam logic [1:0] PCSRC_ALUOUT = 2'd1;
    localparam logic [1:0] PCSRC_JUMP   = 2'd2;

    typedef struct packed {
        logic       pc_write;
        logic       iord;
        logic       ir_write;
        logic       mem_read;
        logic       mem_write;
        logic       mem_to_reg;
        logic       reg_dest;
        logic       reg_write;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic [2:0] alu_op;
        logic [1:0] pc_source;
    } ctrl_t;

    // States whose exit back to FETCH completes an instruction.
    function automatic logic is_retire(input state_t s);
        return (s == S_MEM_WB) || (s == S_MEM_WR) || (s == S_R_WB) ||
               (s == S_BRANCH) || (s == S_JUMP)   || (s == S_ADDI_WB);
    endfunction

endpackage

// File: rtl/ctrl_decode_rom.sv
// rtl/ctrl_decode_rom.sv - combinational state (plus zero flag) to control vector table
module ctrl_decode_rom
    import cpu_ctrl_pkg::*;
(
    input  state_t state_i,
    input  logic   zero_flag_i,
    output ctrl_t  ctrl_o
);

    // One control vector per state; anything not named stays 0 (TRAP is all zero).
    always_comb begin
        ctrl_o = '0;
        case (state_i)
            S_FETCH: begin
                ctrl_o.mem_read  = 1'b1;
                ctrl_o.ir_write  = 1'b1;
                ctrl_o.alu_src_b = SRCB_FOUR;
                ctrl_o.alu_op    = ALUOP_ADD;
                ctrl_o.pc_source = PCSRC_ALU;
                ctrl_o.pc_write  = 1'b1;
            end
            S_DECODE: begin
                ctrl_o.alu_src_b = SRCB_IMM_SH2;
                ctrl_o.alu_op    = ALUOP_ADD;
            end
            S_MEM_ADDR, S_ADDI_EX: begin
                ctrl_o.alu_src_a = 1'b1;
                ctrl_o.alu_src_b = SRCB_IMM;
                ctrl_o.alu_op    = ALUOP_ADD;
            end
            S_MEM_RD: begin
                ctrl_o.mem_read = 1'b1;
                ctrl_o.iord     = 1'b1;
            end
            S_MEM_WB: begin
                ctrl_o.reg_write  = 1'b1;
                ctrl_o.mem_to_reg = 1'b1;
            end
            S_MEM_WR: begin
                ctrl_o.mem_write = 1'b1;
                ctrl_o.iord      = 1'b1;
            end
            S_EXEC_R: begin
                ctrl_o.alu_src_a = 1'b1;
                ctrl_o.alu_src_b = SRCB_RT;
                ctrl_o.alu_op    = ALUOP_FUNCT;
            end
            S_R_WB: begin
                ctrl_o.reg_write = 1'b1;
                ctrl_o.reg_dest  = 1'b1;
            end
            S_BRANCH: begin
                ctrl_o.alu_src_a = 1'b1;
                ctrl_o.alu_src_b = SRCB_RT;
                ctrl_o.alu_op    = ALUOP_SUB;
                ctrl_o.pc_source = PCSRC_ALUOUT;
                ctrl_o.pc_write  = zero_flag_i;
            end
            S_JUMP: begin
                ctrl_o.pc_source = PCSRC_JUMP;
                ctrl_o.pc_write  = 1'b1;
            end
            S_ADDI_WB: begin
                ctrl_o.reg_write = 1'b1;
            end
            default: ctrl_o = '0;
        endcase
    end

endmodule

// File: rtl/multicycle_ctrl.sv
// rtl/multicycle_ctrl.sv - multi-cycle control sequencer FSM; MEM_WAIT_EN adds memory wait states
module multicycle_ctrl
    import cpu_ctrl_pkg::*;
#(
    parameter int OPW = 6,
    parameter int STW = 4
) (
    input  logic           Clk,
    input  logic           Rst,
    input  logic [OPW-1:0] Opcode,
    input  logic           ZeroFlag,
    input  logic           Mem_Ready,
    output logic           PC_Write,
    output logic           IorD,
    output logic           IR_Write,
    output logic           Sig_Mem_Read,
    output logic           Sig_Mem_Write,
    output logic           Sig_Mem_to_Reg,
    output logic           RegDest,
    output logic           Sig_Reg_Write,
    output logic           ALUSrcA,
    output logic [1:0]     ALUSrcB,
    output logic [2:0]     ALUOp,
    output logic [1:0]     PCSource,
    output logic           Instr_Done,
    output logic           Illegal,
    output logic [STW-1:0] State
);

    state_t state_q, state_d;
    logic   illegal_q, illegal_d;
    logic   done_q, done_d;
    logic   mem_go;
    ctrl_t  rom_ctrl;

`ifdef MEM_WAIT_EN
    assign mem_go = Mem_Ready;
`else
    logic unused_mem_ready;
    assign unused_mem_ready = Mem_Ready;
    assign mem_go           = 1'b1;
`endif

    // State, sticky illegal flag and retire pulse registers.
    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            state_q   <= S_FETCH;
            illegal_q <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            illegal_q <= illegal_d;
            done_q    <= done_d;
        end
    end

    // Next-state: Opcode only matters in DECODE and MEM_ADDR; memory states may stall on mem_go.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_FETCH:    if (mem_go) state_d = S_DECODE;
            S_DECODE: begin
                if (Opcode == OP_LW || Opcode == OP_SW) state_d = S_MEM_ADDR;
                else if (Opcode == OP_RTYPE)            state_d = S_EXEC_R;
                else if (Opcode == OP_BEQ)              state_d = S_BRANCH;
                else if (Opcode == OP_J)                state_d = S_JUMP;
                else if (Opcode == OP_ADDI)             state_d = S_ADDI_EX;
                else                                    state_d = S_TRAP;
            end
            S_MEM_ADDR: state_d = (Opcode == OP_LW) ? S_MEM_RD : S_MEM_WR;
            S_MEM_RD:   if (mem_go) state_d = S_MEM_WB;
            S_MEM_WB:   state_d = S_FETCH;
            S_MEM_WR:   if (mem_go) state_d = S_FETCH;
            S_EXEC_R:   state_d = S_R_WB;
            S_R_WB:     state_d = S_FETCH;
            S_BRANCH:   state_d = S_FETCH;
            S_JUMP:     state_d = S_FETCH;
            S_ADDI_EX:  state_d = S_ADDI_WB;
            S_ADDI_WB:  state_d = S_FETCH;
            S_TRAP:     state_d = S_TRAP;
            default:    state_d = S_FETCH;
        endcase
    end

    // Retire pulse lands in the first FETCH after a retiring state; illegal latches on entry to TRAP.
    always_comb begin
        done_d    = is_retire(state_q) && (state_d == S_FETCH);
        illegal_d = illegal_q || ((state_q == S_DECODE) && (state_d == S_TRAP));
    end

    ctrl_decode_rom u_rom (
        .state_i     (state_q),
        .zero_flag_i (ZeroFlag),
        .ctrl_o      (rom_ctrl)
    );

    logic fetch_ok;
    assign fetch_ok = (state_q != S_FETCH) || mem_go;

    // Strobes are forced low while reset is asserted; FETCH loads IR/PC only when memory is ready.
    assign PC_Write       = rom_ctrl.pc_write  & fetch_ok & ~Rst;
    assign IR_Write       = rom_ctrl.ir_write  & fetch_ok & ~Rst;
    assign Sig_Mem_Read   = rom_ctrl.mem_read  & ~Rst;
    assign Sig_Mem_Write  = rom_ctrl.mem_write & ~Rst;
    assign Sig_Reg_Write  = rom_ctrl.reg_write & ~Rst;
    assign IorD           = rom_ctrl.iord;
    assign Sig_Mem_to_Reg = rom_ctrl.mem_to_reg;
    assign RegDest        = rom_ctrl.reg_dest;
    assign ALUSrcA        = rom_ctrl.alu_src_a;
    assign ALUSrcB        = rom_ctrl.alu_src_b;
    assign ALUOp          = rom_ctrl.alu_op;
    assign PCSource       = rom_ctrl.pc_source;
    assign Instr_Done     = done_q;
    assign Illegal        = illegal_q;
    assign State          = state_q;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// tb/tb_multicycle_ctrl.sv - table-driven self-checking bench for multicycle_ctrl
module tb_multicycle_ctrl;

    logic       Clk = 1'b0;
    logic       Rst = 1'b1;
    logic [5:0] Opcode = 6'h00;
    logic       ZeroFlag = 1'b0;
    logic       Mem_Ready = 1'b1;
    logic       PC_Write, IorD, IR_Write, Sig_Mem_Read, Sig_Mem_Write;
    logic       Sig_Mem_to_Reg, RegDest, Sig_Reg_Write, ALUSrcA;
    logic [1:0] ALUSrcB, PCSource;
    logic [2:0] ALUOp;
    logic       Instr_Done, Illegal;
    logic [3:0] State;

    multicycle_ctrl dut (
        .Clk(Clk), .Rst(Rst), .Opcode(Opcode), .ZeroFlag(ZeroFlag), .Mem_Ready(Mem_Ready),
        .PC_Write(PC_Write), .IorD(IorD), .IR_Write(IR_Write), .Sig_Mem_Read(Sig_Mem_Read),
        .Sig_Mem_Write(Sig_Mem_Write), .Sig_Mem_to_Reg(Sig_Mem_to_Reg), .RegDest(RegDest),
        .Sig_Reg_Write(Sig_Reg_Write), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ALUOp(ALUOp),
        .PCSource(PCSource), .Instr_Done(Instr_Done), .Illegal(Illegal), .State(State)
    );

    always #5 Clk = ~Clk;

    // {PC_Write, IorD, IR_Write, MemRd, MemWr, MemToReg, RegDest, RegWr, SrcA, SrcB[1:0], ALUOp[2:0], PCSrc[1:0]}
    logic [15:0] act_ctrl;
    assign act_ctrl = {PC_Write, IorD, IR_Write, Sig_Mem_Read, Sig_Mem_Write, Sig_Mem_to_Reg,
                       RegDest, Sig_Reg_Write, ALUSrcA, ALUSrcB, ALUOp, PCSource};

    localparam logic [15:0] V_FETCH   = 16'hB020;
    localparam logic [15:0] V_FETCH_R = 16'h0020;
    localparam logic [15:0] V_FETCH_W = 16'h1020;
    localparam logic [15:0] V_DECODE  = 16'h0060;
    localparam logic [15:0] V_MADDR   = 16'h00C0;
    localparam logic [15:0] V_MRD     = 16'h5000;
    localparam logic [15:0] V_MWB     = 16'h0500;
    localparam logic [15:0] V_MWR     = 16'h4800;
    localparam logic [15:0] V_EXECR   = 16'h0088;
    localparam logic [15:0] V_RWB     = 16'h0300;
    localparam logic [15:0] V_BR_T    = 16'h8085;
    localparam logic [15:0] V_BR_N    = 16'h0085;
    localparam logic [15:0] V_JUMP    = 16'h8002;
    localparam logic [15:0] V_AWB     = 16'h0100;
    localparam logic [15:0] V_ZERO    = 16'h0000;

    typedef struct {
        logic [5:0]  op;
        logic        zero;
        logic [3:0]  st;
        logic [15:0] ctrl;
        logic        done;
        logic        ill;
    } vec_t;

    vec_t tbl[$];
    int   n_cmp = 0;
    int   n_err = 0;

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic check_all(input string tag, input logic [3:0] st, input logic [15:0] ctrl,
                             input logic done, input logic ill);
        check({tag, ".state"}, {12'd0, State}, {12'd0, st});
        check({tag, ".ctrl"}, act_ctrl, ctrl);
        check({tag, ".done"}, {15'd0, Instr_Done}, {15'd0, done});
        check({tag, ".illegal"}, {15'd0, Illegal}, {15'd0, ill});
    endtask

    initial begin
        // op, zero, state, ctrl, done, illegal
        tbl.push_back('{6'h00, 1'b0, 4'd0,  V_FETCH,  1'b0, 1'b0});
        tbl.push_back('{6'h00, 1'b0, 4'd1,  V_DECODE, 1'b0, 1'b0});
        tbl.push_back('{6'h00, 1'b0, 4'd6,  V_EXECR,  1'b0, 1'b0});
        tbl.push_back('{6'h3F, 1'b0, 4'd7,  V_RWB,    1'b0, 1'b0});
        tbl.push_back('{6'h23, 1'b0, 4'd0,  V_FETCH,  1'b1, 1'b0});
        tbl.push_back('{6'h23, 1'b0, 4'd1,  V_DECODE, 1'b0, 1'b0});
        tbl.push_back('{6'h23, 1'b0, 4'd2,  V_MADDR,  1'b0, 1'b0});
        tbl.push_back('{6'h3F, 1'b0, 4'd3,  V_MRD,    1'b0, 1'b0});
        tbl.push_back('{6'h00, 1'b0, 4'd4,  V_MWB,    1'b0, 1'b0});
        tbl.push_back('{6'h2B, 1'b0, 4'd0,  V_FETCH,  1'b1, 1'b0});
        tbl.push_back('{6'h2B, 1'b0, 4'd1,  V_DECODE, 1'b0, 1'b0});
        tbl.push_back('{6'h2B, 1'b0, 4'd2,  V_MADDR,  1'b0, 1'b0});
        tbl.push_back('{6'h2B, 1'b0, 4'd5,  V_MWR,    1'b0, 1'b0});
        tbl.push_back('{6'h04, 1'b0, 4'd0,  V_FETCH,  1'b1, 1'b0});
        tbl.push_back('{6'h04, 1'b0, 4'd1,  V_DECODE, 1'b0, 1'b0});
        tbl.push_back('{6'h04, 1'b1, 4'd8,  V_BR_T,   1'b0, 1'b0});
        tbl.push_back('{6'h04, 1'b0, 4'd0,  V_FETCH,  1'b1, 1'b0});
        tbl.push_back('{6'h04, 1'b0, 4'd1,  V_DECODE, 1'b0, 1'b0});
        tbl.push_back('{6'h04, 1'b0, 4'd8,  V_BR_N,   1'b0, 1'b0});
        tbl.push_back('{6'h02, 1'b0, 4'd0,  V_FETCH,  1'b1, 1'b0});
        tbl.push_back('{6'h02, 1'b0, 4'd1,  V_DECODE, 1'b0, 1'b0});
        tbl.push_back('{6'h02, 1'b0, 4'd9,  V_JUMP,   1'b0, 1'b0});
        tbl.push_back('{6'h08, 1'b0, 4'd0,  V_FETCH,  1'b1, 1'b0});
        tbl.push_back('{6'h08, 1'b0, 4'd1,  V_DECODE, 1'b0, 1'b0});
        tbl.push_back('{6'h23, 1'b0, 4'd10, V_MADDR,  1'b0, 1'b0});
        tbl.push_back('{6'h2B, 1'b0, 4'd11, V_AWB,    1'b0, 1'b0});
        tbl.push_back('{6'h3F, 1'b0, 4'd0,  V_FETCH,  1'b1, 1'b0});
        tbl.push_back('{6'h3F, 1'b0, 4'd1,  V_DECODE, 1'b0, 1'b0});
        tbl.push_back('{6'h00, 1'b0, 4'd12, V_ZERO,   1'b0, 1'b1});

        // Reset state while Rst is held: FETCH, strobes gated.
        #2;
        check_all("reset", 4'd0, V_FETCH_R, 1'b0, 1'b0);
        @(negedge Clk);
        Rst = 1'b0;

        for (int i = 0; i < tbl.size(); i++) begin
            Opcode   = tbl[i].op;
            ZeroFlag = tbl[i].zero;
            #1;
            check_all($sformatf("row%0d", i), tbl[i].st, tbl[i].ctrl, tbl[i].done, tbl[i].ill);
            @(negedge Clk);
        end

        // TRAP is absorbing with all outputs low, whatever the inputs do.
        for (int c = 0; c < 20; c++) begin
            Opcode   = 6'(c * 7);
            ZeroFlag = c[0];
            #1;
            check_all($sformatf("trap%0d", c), 4'd12, V_ZERO, 1'b0, 1'b1);
            @(negedge Clk);
        end

        // Asynchronous reset out of TRAP.
        ZeroFlag = 1'b0;
        #2 Rst = 1'b1;
        #1;
        check_all("trap_rst", 4'd0, V_FETCH_R, 1'b0, 1'b0);
        @(negedge Clk);
        Rst    = 1'b0;
        Opcode = 6'h2B;

`ifdef MEM_WAIT_EN
        Mem_Ready = 1'b0;
        for (int c = 0; c < 3; c++) begin
            #1;
            check_all($sformatf("wait%0d", c), 4'd0, V_FETCH_W, 1'b0, 1'b0);
            @(negedge Clk);
        end
        Mem_Ready = 1'b1;
        #1;
        check_all("wait_go", 4'd0, V_FETCH, 1'b0, 1'b0);
        @(negedge Clk);
`else
        Mem_Ready = 1'b0;
        #1;
        check_all("noready", 4'd0, V_FETCH, 1'b0, 1'b0);
        @(negedge Clk);
        Mem_Ready = 1'b1;
`endif
        #1;
        check_all("sw_dec", 4'd1, V_DECODE, 1'b0, 1'b0);
        @(negedge Clk);
        #1;
        check_all("sw_addr", 4'd2, V_MADDR, 1'b0, 1'b0);
        @(negedge Clk);
        #1;
        check_all("sw_wr", 4'd5, V_MWR, 1'b0, 1'b0);

        // Reset mid-cycle during MEM_WR takes effect before the next clock edge.
        #2 Rst = 1'b1;
        #1;
        check("midrst.memwrite", {15'd0, Sig_Mem_Write}, 16'd0);
        check_all("midrst", 4'd0, V_FETCH_R, 1'b0, 1'b0);
        @(negedge Clk);
        check_all("rst_held", 4'd0, V_FETCH_R, 1'b0, 1'b0);
        Rst = 1'b0;
        #1;
        check_all("post_rst", 4'd0, V_FETCH, 1'b0, 1'b0);
        @(negedge Clk);
        #1;
        check_all("post_rst_dec", 4'd1, V_DECODE, 1'b0, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
